reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of registers; power of two, at least 2.
REQ-003 Parameter RESET_VAL, default 0, reset contents of registers 1..DEPTH-1.
REQ-004 Derived constant ADDR_W = clog2(DEPTH); it is not overridable.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 rd_addr1, rd_addr2  in  ADDR_W  read port addresses.
REQ-008 rd_data1, rd_data2  out  DATA_W  read data, combinational from address.
REQ-009 busy1, busy2  out  1  pending-write flag for rd_addr1 / rd_addr2, combinational.
REQ-010 wr_en  in  1  writeback strobe.
REQ-011 wr_addr  in  ADDR_W  writeback destination.
REQ-012 wr_data  in  DATA_W  writeback value.
REQ-013 resv_en  in  1  issue-stage reservation strobe; marks a destination pending.
REQ-014 resv_addr  in  ADDR_W  reserved destination.
REQ-015 flush  in  1  synchronous clear of all pending flags; register data is kept.

Function
REQ-016 The write commits wr_data to wr_addr at the rising edge when wr_en=1, whatever the data value, including zero.
REQ-017 Register 0 always reads 0; writes to it and reservations of it are discarded, and its busy flag is always 0.
REQ-018 The scoreboard holds one busy bit per register; resv_en=1 sets bit[resv_addr] at the edge.
REQ-019 wr_en=1 clears bit[wr_addr] at the edge.
REQ-020 If resv_en and wr_en target the same register in the same cycle, the reservation wins and the bit ends at 1.
REQ-021 flush=1 clears every busy bit at the edge and overrides a same-cycle reservation; a same-cycle write still commits its data.
REQ-022 busyN = bit[rd_addrN], with the adjustment in REQ-023 applied.
REQ-023 If wr_en=1, wr_addr=rd_addrN and there is no same-cycle reservation of that address, busyN reads 0 in that cycle.
REQ-024 rd_dataN shows the stored value of rd_addrN, with zero cycles of latency from the address.
REQ-025 Both read ports are independent and may address the same register.
REQ-026 A write and a reservation may target different registers in the same cycle without interaction.

Reset
REQ-027 When rst=0, registers 1..DEPTH-1 are set to RESET_VAL and all busy bits to 0 immediately, without waiting for clk.
REQ-028 While rst=0, writes, reservations and flush are ignored.
REQ-029 Reset asserted mid-operation discards all pending state with no partial update.
REQ-030 Outputs under reset: rd_dataN = RESET_VAL, or 0 for address 0; busyN = 0.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN controls write-through bypass on the read ports.
REQ-032 When it is defined and wr_en=1 with wr_addr=rd_addrN≠0, rd_dataN equals wr_data in that same cycle.
REQ-033 When it is not defined, rd_dataN shows the pre-edge stored value, and the new value appears the cycle after the write.
REQ-034 REQ-023 applies in both configurations.

Structure
REQ-035 A shared package regfile_pkg holds the default DATA_W and DEPTH, the ADDR_W function and the type reg_addr_t.
REQ-036 The scoreboard is a sub-module, reg_scoreboard (busy vector, set/clear/flush priority); storage and read muxing stay in reg_file_sb.

Verification
REQ-037 Reset: hold rst=0, read addresses 0, 5 and 31 with RESET_VAL=2 -> rd_data = 0, 2, 2; busy = 0.
REQ-038 Write then read: wr_en, addr 7, data 0x0 over prior 0xDEAD -> the next cycle reads 0x0; a write of 0x1234 to addr 0 -> reg 0 still reads 0.
REQ-039 Scoreboard: reserve 9, then read 9 -> busy1=1; write 9 = 0xAB -> busy1=0 in the write cycle, and 0xAB is read the next cycle (same cycle only with REGFILE_BYPASS_EN).
REQ-040 Collision: reserve 4 and write 4 in the same cycle -> busy stays 1 afterwards; reserve 3 plus flush in the same cycle -> busy 0.
REQ-041 Bypass: with the macro defined, write addr 12 = 0x55AA while both ports read 12 -> both ports show 0x55AA in that cycle; without the macro they show the old value.
REQ-042 Async reset mid-run: assert rst=0 between clock edges with busy 6 set and reg 6 = 0x77 -> busy and reg 6 = RESET_VAL immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register file slice: default data width and
//   depth, the address-width helper used to size address ports, and the
//   default-sized register address type.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 32;

  // Address width for a register file of the given depth. A depth of 2
  // still needs one address bit, so the result is never below 1.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int DEFAULT_ADDR_W = addr_w(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   One pending-write (busy) bit per register, plus the combinational busy
//   lookup for the two read ports.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous active-low reset, clears every bit
//   resv_en, resv_addr    reservation: sets the destination's bit
//   wr_en, wr_addr        writeback: clears the destination's bit
//   flush                 clears every bit (beats a same-cycle reservation)
//   rd_addr1, rd_addr2    read port addresses
//   busy1, busy2          busy flag of each read port's register
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             clr1;
  logic             clr2;

  // Next busy vector. Later assignments override earlier ones, so the
  // order encodes priority: write clears, reservation sets over it, flush
  // clears everything, and register 0 is never marked busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (resv_en) busy_d[resv_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy vector register; reset empties it without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A writeback landing on the read address this cycle resolves the
  // hazard early, unless a reservation of the same register re-arms it.
  assign clr1 = wr_en && (wr_addr == rd_addr1) &&
                !(resv_en && (resv_addr == rd_addr1));
  assign clr2 = wr_en && (wr_addr == rd_addr2) &&
                !(resv_en && (resv_addr == rd_addr2));

  assign busy1 = busy_q[rd_addr1] && !clr1;
  assign busy2 = busy_q[rd_addr2] && !clr2;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Two-read, one-write register file with a per-register pending-write
//   scoreboard. Register 0 is hardwired to zero.
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, a same-cycle write to the addressed
//                      register (other than 0) is forwarded to the read
//                      data; otherwise reads show the stored value.
//
// Ports
//   clk                          rising-edge clock
//   rst                          asynchronous active-low reset
//   rd_addr1, rd_addr2           read addresses
//   rd_data1, rd_data2           combinational read data
//   busy1, busy2                 combinational pending-write flags
//   wr_en, wr_addr, wr_data      writeback port
//   resv_en, resv_addr           issue-stage reservation port
//   flush                        clears all pending flags, data is kept
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter  int               DATA_W    = DEFAULT_DATA_W,
  parameter  int               DEPTH     = DEFAULT_DEPTH,
  parameter  logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  input  logic              flush
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Register storage. Entry 0 is loaded with zero and never written, so
  // writes to it are simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port 1. The bypass is gated by rst so that a write strobe held
  // during reset cannot leak onto the read data.
  always_comb begin
    rd_data1 = mem[rd_addr1];
    if (rd_addr1 == '0) begin
      rd_data1 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (rst && wr_en && (wr_addr == rd_addr1) && (rd_addr1 != '0)) begin
      rd_data1 = wr_data;
    end
`endif
  end

  // Read port 2, identical to port 1 and fully independent of it.
  always_comb begin
    rd_data2 = mem[rd_addr2];
    if (rd_addr2 == '0) begin
      rd_data2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (rst && wr_en && (wr_addr == rd_addr2) && (rd_addr2 != '0)) begin
      rd_data2 = wr_data;
    end
`endif
  end

  reg_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .flush     (flush),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
//   Directed bench for reg_file_sb (DATA_W=32, DEPTH=32, RESET_VAL=2).
//   Stimulus pushes the hand-computed expected outputs for the current
//   cycle into a queue; a monitor on the falling edge pops and compares.
module tb_reg_file_sb;
  import regfile_pkg::*;

  localparam logic [31:0] RV = 32'd2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  reg_addr_t   rd_addr1;
  reg_addr_t   rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        busy1;
  logic        busy2;
  logic        wr_en;
  reg_addr_t   wr_addr;
  logic [31:0] wr_data;
  logic        resv_en;
  reg_addr_t   resv_addr;
  logic        flush;

  typedef struct {
    string       name;
    int          cyc;
    logic [3:0]  mask;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t expq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  reg_file_sb #(
    .DATA_W    (32),
    .DEPTH     (32),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .busy1     (busy1),
    .busy2     (busy2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .flush     (flush)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to tie each expectation to the cycle it was issued in.
  always @(posedge clk) cyc <= cyc + 1;

  // Mask bits: [0] rd_data1, [1] rd_data2, [2] busy1, [3] busy2.
  task automatic checkOutput(input string name, input logic [3:0] mask,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic b1, input logic b2);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.mask = mask;
    e.d1   = d1;
    e.d2   = d2;
    e.b1   = b1;
    e.b2   = b2;
    expq.push_back(e);
  endtask

  // Advance to just after the next rising edge, then drive all inputs.
  task automatic applyStimulus(input logic we, input reg_addr_t wa,
                               input logic [31:0] wd, input logic re,
                               input reg_addr_t ra, input logic fl,
                               input reg_addr_t a1, input reg_addr_t a2);
    @(posedge clk);
    #1;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    resv_en   = re;
    resv_addr = ra;
    flush     = fl;
    rd_addr1  = a1;
    rd_addr2  = a2;
  endtask

  // Monitor: mid-cycle, compare every expectation issued for this cycle.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      exp_t e;
      e = expq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s stale expectation cycle %0d now %0d", e.name, e.cyc, cyc);
      end else begin
        if (e.mask[0]) begin
          checks++;
          if (rd_data1 !== e.d1) begin
            errors++;
            $display("[TB] FAIL %s rd_data1 got %h want %h", e.name, rd_data1, e.d1);
          end
        end
        if (e.mask[1]) begin
          checks++;
          if (rd_data2 !== e.d2) begin
            errors++;
            $display("[TB] FAIL %s rd_data2 got %h want %h", e.name, rd_data2, e.d2);
          end
        end
        if (e.mask[2]) begin
          checks++;
          if (busy1 !== e.b1) begin
            errors++;
            $display("[TB] FAIL %s busy1 got %b want %b", e.name, busy1, e.b1);
          end
        end
        if (e.mask[3]) begin
          checks++;
          if (busy2 !== e.b2) begin
            errors++;
            $display("[TB] FAIL %s busy2 got %b want %b", e.name, busy2, e.b2);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0; flush = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;

    // Reset contents and flags.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
    checkOutput("rst_a0_a5", 4'hF, 32'd0, RV, 1'b0, 1'b0);
    applyStimulus(1, 5, 32'hFFFF, 1, 5, 1, 31, 5);
    checkOutput("rst_a31_wr_ignored", 4'hF, RV, RV, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 31, 5);
    checkOutput("rst_after_wr", 4'hF, RV, RV, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    rst = 1'b1;

    // Zero-valued write over prior data, and register 0 stays zero.
    applyStimulus(1, 7, 32'hDEAD, 0, 0, 0, 7, 0);
    checkOutput("wr7_dead", 4'h5, BYP ? 32'hDEAD : RV, 32'd0, 1'b0, 1'b0);
    applyStimulus(1, 7, 32'h0, 0, 0, 0, 7, 0);
    checkOutput("wr7_zero", 4'h1, BYP ? 32'h0 : 32'hDEAD, 32'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("rd7_zero", 4'h1, 32'h0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1, 0, 32'h1234, 1, 0, 0, 0, 0);
    checkOutput("wr0", 4'hF, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd0", 4'hF, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reservation then writeback of register 9.
    applyStimulus(0, 0, 0, 1, 9, 0, 9, 0);
    checkOutput("resv9", 4'h4, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
    checkOutput("busy9", 4'h5, RV, 32'd0, 1'b1, 1'b0);
    applyStimulus(1, 9, 32'hAB, 0, 0, 0, 9, 0);
    checkOutput("wr9", 4'h5, BYP ? 32'hAB : RV, 32'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
    checkOutput("rd9", 4'h5, 32'hAB, 32'd0, 1'b0, 1'b0);

    // Reservation beats a same-cycle write; flush beats a reservation.
    applyStimulus(1, 4, 32'h44, 1, 4, 0, 4, 0);
    checkOutput("resv_wr4", 4'h5, BYP ? 32'h44 : RV, 32'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0);
    checkOutput("busy4", 4'h5, 32'h44, 32'd0, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1, 3, 1, 3, 4);
    checkOutput("resv3_flush", 4'hC, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
    checkOutput("after_flush", 4'hF, RV, 32'h44, 1'b0, 1'b0);

    // Both ports reading the register being written.
    applyStimulus(1, 12, 32'h55AA, 0, 0, 0, 12, 12);
    checkOutput("byp12", 4'hF, BYP ? 32'h55AA : RV, BYP ? 32'h55AA : RV, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 12, 12);
    checkOutput("rd12", 4'h3, 32'h55AA, 32'h55AA, 1'b0, 1'b0);

    // Write and reservation of different registers in one cycle.
    applyStimulus(1, 9, 32'hCD, 1, 6, 0, 6, 9);
    checkOutput("resv6_wr9", 4'hE, RV, BYP ? 32'hCD : 32'hAB, 1'b0, 1'b0);
    applyStimulus(1, 6, 32'h77, 1, 6, 0, 6, 9);
    checkOutput("resv_wr6", 4'hF, BYP ? 32'h77 : RV, 32'hCD, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 9);
    checkOutput("rd6", 4'hF, 32'h77, 32'hCD, 1'b1, 1'b0);

    // Reset asserted between clock edges takes effect immediately.
    @(posedge clk);
    #2;
    rst = 1'b0;
    checkOutput("async_rst", 4'hF, RV, RV, 1'b0, 1'b0);
    applyStimulus(1, 6, 32'h99, 1, 6, 0, 6, 9);
    checkOutput("rst_hold_wr6", 4'hF, RV, RV, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 9);
    checkOutput("rst_hold_rd6", 4'h5, RV, RV, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 0);
    checkOutput("post_rst_rd6", 4'hF, RV, 32'd0, 1'b0, 1'b0);

    // Drain the queue with a bounded wait.
    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      errors += expq.size();
      $display("[TB] FAIL drain %0d expectations left, want 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
